// File: rtl/sbox_serial_ctrl_pkg.sv
// Shared types, sizes and the DES S-box contents for the serial substitution block.
// The ROM address packs the box index with the row/column derived from a 6-bit chunk.
package sbox_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned NUM_BOX = 8;
  localparam int unsigned ROM_AW  = 9;
  localparam int unsigned ROM_DW  = 4;
  localparam int unsigned CHUNK_W = 6;
  localparam int unsigned IN_W    = NUM_BOX * CHUNK_W;
  localparam int unsigned OUT_W   = NUM_BOX * ROM_DW;

  // One 64-bit word per {box, row}; column 0 is the most significant nibble.
  localparam logic [63:0] SBOX_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [ROM_AW-1:0] sbox_addr(input logic [2:0] box,
                                                   input logic [CHUNK_W-1:0] chunk);
    return {box, chunk[5], chunk[0], chunk[4:1]};
  endfunction

  function automatic logic [ROM_DW-1:0] sbox_rom_word(input logic [ROM_AW-1:0] addr);
    logic [63:0] row_bits;
    row_bits = SBOX_ROWS[addr[8:4]];
    return row_bits[{~addr[3:0], 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sbox_serial_ctrl_sbox_all_rom.sv
// Shared 512x4 S-box ROM with a one-cycle registered read; no reset on the read register.
module sbox_all_rom
  import sbox_serial_ctrl_pkg::*;
#(
  parameter string SBOX_FILE = "sbox_all.txt"
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] dout
);

  // Contents are elaborated from the package constant table; the file name
  // parameter is kept so existing instantiations continue to elaborate.
  localparam string unused_sbox_file = SBOX_FILE;

  logic [ROM_DW-1:0] dout_d;
  logic [ROM_DW-1:0] dout_q;

  always_comb begin
    dout_d = sbox_rom_word(addr);
  end

  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/sbox_serial_ctrl.sv
// DES S-box substitution of a 48-bit word, time-sharing one ROM across the 8 boxes,
// one lookup per cycle, with a valid/ready handshake on both sides.
module sbox_serial_ctrl
  import sbox_serial_ctrl_pkg::*;
#(
  parameter string SBOX_FILE = "sbox_all.txt"
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic              cap_q, cap_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic [ROM_AW-1:0] rom_addr;
  logic [ROM_DW-1:0] rom_dout;

  sbox_all_rom #(
    .SBOX_FILE(SBOX_FILE)
  ) u_rom (
    .clk (clk),
    .addr(rom_addr),
    .dout(rom_dout)
  );

  // The latched word shifts left each issue cycle, so the current chunk is always the top 6 bits.
  assign rom_addr = sbox_addr(cnt_q, data_q[IN_W-1 -: CHUNK_W]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      cap_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      cap_q    <= cap_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ISSUE;
          cnt_d   = '0;
          data_d  = in_data;
        end
      end
      ISSUE: begin
        data_d = {data_q[IN_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
        if (cnt_q == 3'd7) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Each ROM read lands one cycle after its issue cycle; cap_q marks that landing cycle.
  always_comb begin
    cap_d    = (state_q == ISSUE);
    result_d = result_q;
    if (cap_q) begin
      result_d = {result_q[OUT_W-ROM_DW-1:0], rom_dout};
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = result_q;
  end

endmodule

// File: tb/tb_sbox_serial_ctrl.sv
// Self-checking bench: directed handshake/latency/reset steps, then 1000 random words
// against a table-driven DES S-box model with random consumer stalls.
module tb_sbox_serial_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam int SBOX_TBL [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  sbox_serial_ctrl #(
    .SBOX_FILE("sbox_all.txt")
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sbox(input logic [47:0] x);
    logic [31:0] r;
    int c, row, col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c   = int'((x >> (42 - 6 * b)) & 48'h3F);
      row = ((c >> 5) * 2) + (c & 1);
      col = (c >> 1) & 15;
      r   = {r[27:0], 4'(SBOX_TBL[b][row * 16 + col])};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; the result must appear on the 10th edge
  // counting the accepting edge as the first.
  task automatic expect_result(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, "_early_valid"}, 48'(out_valid), 48'd0);
    end
    tick();
    check({tag, "_valid"}, 48'(out_valid), 48'd1);
    check({tag, "_data"}, 48'(out_data), 48'(exp));
  endtask

  initial begin
    logic [47:0] w;
    logic [63:0] r64;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int unsigned sent, recv, cycles;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_out_data", 48'(out_data), 48'd0);
    rstn = 1'b1;
    tick();
    check("rst_in_ready", 48'(in_ready), 48'd1);

    // zero word with out_ready high: exact latency, one-cycle DONE
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 48'h0;
    tick();
    in_valid = 1'b0;
    check("zero_in_ready_low", 48'(in_ready), 48'd0);
    check("zero_busy", 48'(busy), 48'd1);
    expect_result("zero", 32'hEFA72C4D);
    tick();
    check("zero_done_one_cycle", 48'(out_valid), 48'd0);
    check("zero_in_ready_back", 48'(in_ready), 48'd1);
    check("zero_data_retained", 48'(out_data), 48'hEFA72C4D);

    // back-to-back with in_valid held
    in_valid = 1'b1;
    in_data  = 48'h0;
    tick();
    check("b2b_accept0", 48'(busy), 48'd1);
    in_data = 48'hFFFF_FFFF_FFFF;
    expect_result("b2b0", 32'hEFA72C4D);
    tick();
    check("b2b_hs_idle", 48'(in_ready), 48'd1);
    tick();
    check("b2b_accept1", 48'(busy), 48'd1);
    in_valid = 1'b0;
    expect_result("b2b1", 32'hD9CE3DCB);
    tick();
    check("b2b_end_idle", 48'(in_ready), 48'd1);

    // backpressure: 20 stalled cycles in DONE, offered input must be ignored
    out_ready = 1'b0;
    r64       = {$urandom, $urandom};
    w         = r64[47:0];
    in_valid  = 1'b1;
    in_data   = w;
    tick();
    in_data = ~w;
    expect_result("bp", ref_sbox(w));
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid_hold", 48'(out_valid), 48'd1);
      check("bp_data_hold", 48'(out_data), 48'(ref_sbox(w)));
      check("bp_in_ready_low", 48'(in_ready), 48'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 48'(out_valid), 48'd0);
    check("bp_release_in_ready", 48'(in_ready), 48'd1);
    tick();
    check("bp_single_hs", 48'(busy), 48'd0);

    // asynchronous reset while the counter is at 4
    in_valid = 1'b1;
    in_data  = 48'hFFFF_FFFF_FFFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy_before", 48'(busy), 48'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", 48'(busy), 48'd0);
    check("mid_rst_out_valid", 48'(out_valid), 48'd0);
    check("mid_rst_out_data", 48'(out_data), 48'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("mid_rst_in_ready", 48'(in_ready), 48'd1);
    in_valid = 1'b1;
    in_data  = 48'h0;
    tick();
    in_valid = 1'b0;
    expect_result("post_rst", 32'hEFA72C4D);
    tick();

    // random words with random gaps and consumer stalls
    sent   = 0;
    recv   = 0;
    cycles = 0;
    while (recv < 1000 && cycles < 60000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      r64       = {$urandom, $urandom};
      in_data   = r64[47:0];
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sbox(in_data));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 48'(out_data), 48'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("rand_data", 48'(out_data), 48'(e));
        end
        recv++;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check("rand_all_received", 48'(recv), 48'd1000);
    check("rand_all_sent", 48'(sent), 48'd1000);
    check("rand_queue_empty", 48'(exp_q.size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
